// File: rtl/norm_unit_if.sv
// -----------------------------------------------------------------------------
// norm_unit_if
// Handshake bundle for the normalizer.
//   Request side : in_valid, in_ready, in_data[15:0], in_dir
//   Result side  : out_valid, out_ready, out_data[15:0], out_shamt[3:0], out_zero
// Modports:
//   master - producer/consumer side (drives requests, takes results)
//   slave  - normalizer side
// -----------------------------------------------------------------------------
interface norm_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_dir;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_shamt;
    logic        out_zero;

    modport master (
        output in_valid, in_data, in_dir, out_ready,
        input  in_ready, out_valid, out_data, out_shamt, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_dir, out_ready,
        output in_ready, out_valid, out_data, out_shamt, out_zero
    );
endinterface

// File: rtl/norm_unit.sv
// -----------------------------------------------------------------------------
// norm_unit
// Multi-cycle 16-bit normalizer. Finds the shift that puts the first set bit
// at bit 15 (left mode, in_dir=0) or bit 0 (right mode, in_dir=1) using a
// four-step binary search (8, 4, 2, 1), and returns the normalized word, the
// shift amount and a zero-input flag.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - norm_unit_if.slave handshake bundle (request and result)
// Latency: accept at E0, result visible after E4; one request in flight.
// -----------------------------------------------------------------------------
module norm_unit (
    input  logic             clk,
    input  logic             rst_n,
    norm_unit_if.slave       bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S8   = 3'd1,
        ST_S4   = 3'd2,
        ST_S2   = 3'd3,
        ST_S1   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t      state_r;
    logic [15:0] work_r;
    logic [3:0]  count_r;
    logic        dir_r;
    logic        zero_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [15:0] out_data_r;
    logic [3:0]  out_shamt_r;
    logic        out_zero_r;

    logic [4:0]  step_k_s;
    logic        fire_s;
    logic [15:0] next_work_s;
    logic [3:0]  next_count_s;

    // A step fires when the k bits about to be shifted out are all zero:
    // the top k bits in left mode, the bottom k bits in right mode.
    function automatic logic step_fires(input logic [15:0] w,
                                        input logic        dir,
                                        input logic [4:0]  k);
        logic [15:0] mask;
        if (dir) begin
            mask = ~(16'hFFFF << k);
        end else begin
            mask = ~(16'hFFFF >> k);
        end
        return (w & mask) == 16'h0000;
    endfunction

    // Step size of the current search stage and the resulting work/count.
    always_comb begin
        step_k_s = 5'd0;
        case (state_r)
            ST_S8:   step_k_s = 5'd8;
            ST_S4:   step_k_s = 5'd4;
            ST_S2:   step_k_s = 5'd2;
            ST_S1:   step_k_s = 5'd1;
            default: step_k_s = 5'd0;
        endcase

        fire_s = step_fires(work_r, dir_r, step_k_s);

        if (fire_s) begin
            if (dir_r) begin
                next_work_s = work_r >> step_k_s;
            end else begin
                next_work_s = work_r << step_k_s;
            end
            next_count_s = count_r + step_k_s[3:0];
        end else begin
            next_work_s  = work_r;
            next_count_s = count_r;
        end
    end

    // Control FSM, search datapath and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            work_r      <= 16'h0000;
            count_r     <= 4'd0;
            dir_r       <= 1'b0;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 16'h0000;
            out_shamt_r <= 4'd0;
            out_zero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        work_r     <= bus.in_data;
                        dir_r      <= bus.in_dir;
                        count_r    <= 4'd0;
                        zero_r     <= (bus.in_data == 16'h0000);
                        in_ready_r <= 1'b0;
                        state_r    <= ST_S8;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_S8: begin
                    work_r  <= next_work_s;
                    count_r <= next_count_s;
                    state_r <= ST_S4;
                end
                ST_S4: begin
                    work_r  <= next_work_s;
                    count_r <= next_count_s;
                    state_r <= ST_S2;
                end
                ST_S2: begin
                    work_r  <= next_work_s;
                    count_r <= next_count_s;
                    state_r <= ST_S1;
                end
                ST_S1: begin
                    // Last step goes straight into the result registers so
                    // they change only on entry to DONE.
                    work_r      <= next_work_s;
                    count_r     <= next_count_s;
                    out_data_r  <= next_work_s;
                    out_shamt_r <= next_count_s;
                    out_zero_r  <= zero_r;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_shamt = out_shamt_r;
    assign bus.out_zero  = out_zero_r;

endmodule

// File: tb/tb_norm_unit.sv
// -----------------------------------------------------------------------------
// tb_norm_unit
// Self-checking bench for norm_unit: directed cases, backpressure, async reset
// abort and a randomized back-to-back sweep against a bit-scanning reference.
// -----------------------------------------------------------------------------
module tb_norm_unit;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    norm_unit_if bus ();

    norm_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: scan for the first set bit from the relevant end.
    function automatic void ref_norm(input  logic [15:0] d,
                                     input  logic        dir,
                                     output logic [15:0] od,
                                     output logic [3:0]  os,
                                     output logic        oz);
        int n;
        n = 0;
        if (d == 16'h0000) begin
            od = 16'h0000;
            os = 4'd15;
            oz = 1'b1;
        end else begin
            if (dir == 1'b0) begin
                while (d[15 - n] == 1'b0) n++;
                od = d << n;
            end else begin
                while (d[n] == 1'b0) n++;
                od = d >> n;
            end
            os = n[3:0];
            oz = 1'b0;
        end
    endfunction

    // Present a request at the current negedge and hold it until accepted.
    task automatic send(input logic [15:0] d, input logic dir);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_dir   = dir;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts negedges since the accept edge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout: out_valid=%b required 1", bus.out_valid);
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0",
                     bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.out_data !== 16'h0000 || bus.out_shamt !== 4'd0 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: data=%h shamt=%0d zero=%b required 0000 0 0",
                     bus.out_data, bus.out_shamt, bus.out_zero);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b required 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_latency();
        int lat;
        send(16'h0001, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL latency: got %0d edges required 5", lat);
        end
        checks++;
        if (bus.out_data !== 16'h8000 || bus.out_shamt !== 4'd15 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL latency_result: data=%h shamt=%0d zero=%b required 8000 15 0",
                     bus.out_data, bus.out_shamt, bus.out_zero);
        end
        take();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL handoff: in_ready=%b out_valid=%b required 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] t_in   [7] = '{16'h0F00, 16'h0F00, 16'h8000, 16'h0000, 16'h0000, 16'h8001, 16'h0003};
        logic        t_dir  [7] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
        logic [15:0] t_out  [7] = '{16'hF000, 16'h000F, 16'h0001, 16'h0000, 16'h0000, 16'h8001, 16'h0003};
        logic [3:0]  t_sh   [7] = '{4'd4,     4'd8,     4'd15,    4'd15,    4'd15,    4'd0,     4'd0};
        logic        t_zero [7] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
        int lat;
        for (int i = 0; i < 7; i++) begin
            send(t_in[i], t_dir[i]);
            wait_out(lat);
            checks++;
            if (bus.out_data !== t_out[i] || bus.out_shamt !== t_sh[i] || bus.out_zero !== t_zero[i]) begin
                errors++;
                $display("FAIL directed_%0d: in=%h dir=%b got %h/%0d/%b required %h/%0d/%b",
                         i, t_in[i], t_dir[i], bus.out_data, bus.out_shamt, bus.out_zero,
                         t_out[i], t_sh[i], t_zero[i]);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ed;
        logic [3:0]  es;
        logic        ez;
        int lat;
        ref_norm(16'h1234, 1'b0, ed, es, ez);
        send(16'h1234, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            // A competing request during DONE must be ignored.
            bus.in_valid = 1'b1;
            bus.in_data  = 16'($urandom);
            bus.in_dir   = 1'($urandom);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_data !== ed || bus.out_shamt !== es || bus.out_zero !== ez) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b ready=%b %h/%0d/%b required 1 0 %h/%0d/%b",
                         i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_shamt,
                         bus.out_zero, ed, es, ez);
            end
        end
        bus.in_valid = 1'b0;
        take();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== ed || bus.out_shamt !== es) begin
            errors++;
            $display("FAIL release: ready=%b valid=%b %h/%0d required 1 0 %h/%0d",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_shamt, ed, es);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        send(16'h00F0, 1'b0);
        @(posedge clk);          // now in S4
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 16'h0000) begin
            errors++;
            $display("FAIL abort: valid=%b ready=%b data=%h required 0 1 0000",
                     bus.out_valid, bus.in_ready, bus.out_data);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        send(16'h0010, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 5 || bus.out_data !== 16'h8000 || bus.out_shamt !== 4'd11 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL after_abort: lat=%0d %h/%0d/%b required 5 8000/11/0",
                     lat, bus.out_data, bus.out_shamt, bus.out_zero);
        end
        take();
    endtask

    task automatic test_random();
        logic [15:0] w, ed;
        logic [3:0]  es;
        logic        ez;
        logic        dir;
        int lat;
        for (int i = 0; i < 2000; i++) begin
            dir = i[0];
            // Pre-shift random words so every shift amount gets exercised.
            w = 16'($urandom);
            if (dir == 1'b0) begin
                w = w >> $urandom_range(0, 16);
            end else begin
                w = w << $urandom_range(0, 16);
            end
            ref_norm(w, dir, ed, es, ez);
            send(w, dir);
            wait_out(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (bus.out_data !== ed || bus.out_shamt !== es || bus.out_zero !== ez) begin
                errors++;
                $display("FAIL random_%0d: in=%h dir=%b got %h/%0d/%b required %h/%0d/%b",
                         i, w, dir, bus.out_data, bus.out_shamt, bus.out_zero, ed, es, ez);
            end
            if (w != 16'h0000) begin
                checks++;
                if ((dir == 1'b0 && (bus.out_data !== (w << bus.out_shamt) || bus.out_data[15] !== 1'b1)) ||
                    (dir == 1'b1 && (bus.out_data !== (w >> bus.out_shamt) || bus.out_data[0] !== 1'b1))) begin
                    errors++;
                    $display("FAIL invariant_%0d: in=%h dir=%b got %h shamt %0d",
                             i, w, dir, bus.out_data, bus.out_shamt);
                end
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/norm_unit.md
# norm_unit

Multi-cycle normalizer for the 16-bit pipelined datapath; the inverse of the barrel shifter. Given a data word, it finds the shift amount that normalizes it (MSB set for left mode, LSB set for right mode) and returns the normalized word plus that amount. The result can feed the shifter's `shift_amt` directly. It sits beside the execute stage behind a valid/ready handshake and resolves the amount in four binary-search steps (8, 4, 2, 1), mirroring the shifter's stage structure.

## Interface
- No parameters; datapath width fixed at 16, shift amount fixed at 4 bits.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  request present.
- `in_ready`  output  1  block can accept; high only in IDLE.
- `in_data`  input  16  word to normalize.
- `in_dir`  input  1  0 = left normalize (count leading zeros), 1 = right normalize (count trailing zeros).
- `out_valid`  output  1  result available; high only in DONE.
- `out_ready`  input  1  consumer takes result.
- `out_data`  output  16  normalized word.
- `out_shamt`  output  4  shift amount applied.
- `out_zero`  output  1  input word was 0x0000.

## Operation
- States: IDLE, S8, S4, S2, S1, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - load work reg <= `in_data`;
  - latch dir <= `in_dir`;
  - count <= 0;
  - zero flag <= (`in_data`==0);
  - go to S8.
- Step Sk (k = 8, 4, 2, 1), one cycle each, k = the stage's step size:
  - left mode: if work[15:16-k]==0, then work <= work << k and count += k;
  - right mode: if work[k-1:0]==0, then work <= work >> k (logical, zero fill) and count += k;
  - otherwise work and count unchanged.
  - Transitions: S8→S4→S2→S1→DONE unconditionally.
- Count is 4 bits and cannot overflow; maximum is 8+4+2+1 = 15.
- Zero input: every step fires, giving `out_data`=0x0000, `out_shamt`=15, `out_zero`=1.
- Nonzero input: left mode gives `out_data[15]`=1; right mode gives `out_data[0]`=1. `out_zero`=0.
- Invariant, left mode nonzero: `out_data` == `in_data` << `out_shamt`. Right mode: `out_data` == `in_data` >> `out_shamt`.
- DONE: `out_valid`=1. When `out_ready`=1, return to IDLE. Otherwise hold; `out_data`, `out_shamt` and `out_zero` stay stable until taken.
- Output registers keep their last result after handoff and update only on entry to DONE.
- `in_data` and `in_dir` are ignored outside IDLE. `out_ready` is ignored outside DONE.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state = IDLE;
  - `in_ready`=1, `out_valid`=0;
  - `out_data`=0x0000, `out_shamt`=0, `out_zero`=0;
  - internal work, count and dir cleared.
- Reset asserted mid-operation (any of S8..DONE) aborts the operation immediately. No result is produced for the aborted request, and the block is in IDLE on the first edge after deassertion.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from inputs to outputs.
- Latency: accept at edge E0. Steps execute at E1..E4. `out_valid` is high starting after E4 (5 edges from accept to result visible).
- Handoff: `out_valid & out_ready` sampled at edge Ek returns the block to IDLE. `in_ready`=1 in the following cycle. Next accept is possible at Ek+1.
- Peak throughput: one result per 6 cycles. There is no overlap between requests.
- Simultaneous `in_valid` during DONE: not accepted; the request must be held by the producer until `in_ready`.

## Test plan
- Reset then left, `in_data`=0x0001 → after 5 edges `out_valid`=1, `out_data`=0x8000, `out_shamt`=15, `out_zero`=0.
- Left, 0x0F00 → `out_data`=0xF000, `out_shamt`=4. Right, 0x0F00 → `out_data`=0x000F, `out_shamt`=8. Right, 0x8000 → 0x0001, `out_shamt`=15.
- Zero input in both modes → `out_data`=0x0000, `out_shamt`=15, `out_zero`=1. Already-normalized input (left 0x8001, right 0x0003) → data unchanged, `out_shamt`=0.
- Backpressure:
  - hold `out_ready`=0 for 10 cycles in DONE → outputs stable and `in_ready`=0 throughout;
  - change `in_data` during the hold → no effect;
  - raise `out_ready` → IDLE next cycle.
- Pulse `rst_n` low asynchronously, between edges, during S4 → `out_valid`=0 and `in_ready`=1 immediately. A fresh request of 0x0010 in left mode then yields 0x8000, `out_shamt`=11.
- Random sweep of 1000 words × both modes, back-to-back with random `out_ready` stalls → every result matches the shift invariant and the leading/trailing-zero count reference model.
